// File: rtl/instr_fetch.sv
// In-order instruction fetch: memory request/grant/rvalid front end, FIFO to decode, branch redirect.
// Define INSTR_FETCH_ALIGN_CHECK_EN to flag branch targets that are not word aligned.
`timescale 1ns/1ps
module instr_fetch #(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   input  logic        instr_ready_i,
   output logic        misaligned_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   typedef enum logic [1:0] {
      RUN,
      WAIT_GNT,
      REDIRECT
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   redir_q, redir_d;
   logic [31:0]   rsp_pc_q;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] rptr_q, wptr_q;
   logic [31:0]   pc_mem   [FIFO_DEPTH];
   logic [31:0]   data_mem [FIFO_DEPTH];

   logic [31:0]   target;
   logic [SW-1:0] used;
   logic          credit;
   logic          req;
   logic          granted;
   logic          resp;
   logic          push;
   logic          pop;

   assign target  = {branch_target_i[31:2], 2'b00};
   assign used    = SW'(cnt_q) + SW'(outst_q);
   assign credit  = used < SW'(FIFO_DEPTH);

   // An ungranted request stays up regardless of credit so it is never withdrawn.
   assign req     = rst_ni & ((state_q != RUN) | credit);
   assign granted = req & instr_gnt_i;
   assign resp    = instr_rvalid_i & (outst_q != '0);
   assign push    = resp & (disc_q == '0) & ~branch_i;
   assign pop     = instr_valid_o & instr_ready_i & ~branch_i;

   assign instr_req_o   = req;
   assign instr_addr_o  = addr_q;
   assign instr_valid_o = (cnt_q != '0);
   assign instr_o       = data_mem[rptr_q];
   assign pc_o          = pc_mem[rptr_q];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      redir_d = redir_q;
      unique case (state_q)
         RUN: begin
            if (branch_i) begin
               if (req & ~instr_gnt_i) begin
                  state_d = REDIRECT;
                  redir_d = target;
               end else begin
                  addr_d = target;
               end
            end else if (granted) begin
               addr_d = addr_q + 32'd4;
            end else if (req) begin
               state_d = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            if (instr_gnt_i) begin
               state_d = RUN;
               addr_d  = branch_i ? target : addr_q + 32'd4;
            end else if (branch_i) begin
               state_d = REDIRECT;
               redir_d = target;
            end
         end
         REDIRECT: begin
            if (instr_gnt_i) begin
               state_d = RUN;
               addr_d  = branch_i ? target : redir_q;
            end else if (branch_i) begin
               redir_d = target;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      outst_d = outst_q + CW'(granted) - CW'(resp);
      disc_d  = disc_q;
      if (branch_i) begin
         // Everything still in flight after this edge belongs to the old path.
         disc_d = outst_d;
      end else begin
         disc_d = disc_q
                - CW'(resp && (disc_q != '0))
                + CW'(granted && (state_q == REDIRECT));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= RUN;
         addr_q   <= BOOT_ADDR;
         redir_q  <= '0;
         rsp_pc_q <= BOOT_ADDR;
         outst_q  <= '0;
         disc_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         redir_q <= redir_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
         if (branch_i) begin
            rsp_pc_q <= target;
         end else if (push) begin
            rsp_pc_q <= rsp_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else if (branch_i) begin
         cnt_q  <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
      end else begin
         if (push) begin
            pc_mem[wptr_q]   <= rsp_pc_q;
            data_mem[wptr_q] <= instr_rdata_i;
            wptr_q           <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   logic mis_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= branch_i & (|branch_target_i[1:0]);
      end
   end

   assign misaligned_o = mis_q;
`else
   logic unused_tgt;

   assign unused_tgt   = ^branch_target_i[1:0];
   assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random memory/branch stimulus, expected
// program-order stream kept as a queue of PCs, separate monitor checks pops.
`timescale 1ns/1ps
module tb_instr_fetch;

   localparam logic [31:0] BOOT  = 32'h0000_0000;
   localparam int          DEPTH = 2;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      int          t;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req;
   logic [31:0] addr;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        branch = 1'b0;
   logic [31:0] target = '0;
   logic        valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        ready = 1'b0;
   logic        misaligned;

   always #5 clk = ~clk;

   instr_fetch #(
      .BOOT_ADDR (BOOT),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .instr_req_o    (req),
      .instr_addr_o   (addr),
      .instr_gnt_i    (gnt),
      .instr_rvalid_i (rvalid),
      .instr_rdata_i  (rdata),
      .branch_i       (branch),
      .branch_target_i(target),
      .instr_valid_o  (valid),
      .instr_o        (instr),
      .pc_o           (pc),
      .instr_ready_i  (ready),
      .misaligned_o   (misaligned)
   );

   int ntests = 0;
   int nfail = 0;
   int cyc = 0;
   int ngrant = 0;
   int npop = 0;
   int rel_cyc = 0;
   int first_v = -1;
   int gnt_pct = 100;
   int dly_lo = 1;
   int dly_hi = 1;
   int rdy_pct = 100;
   int br_pct = 0;
   int spur_pct = 0;
   bit rel = 1'b0;
   bit stale = 1'b0;
   bit frc_br = 1'b0;
   logic [31:0] frc_tgt = '0;
   bit prev_req = 1'b0;
   bit prev_gnt = 1'b0;
   bit prev_rst = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] exp_next = BOOT;
   bit mis_exp = 1'b0;

   pend_t       pend[$];
   logic [31:0] exp_q[$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
   endfunction

   function automatic logic [31:0] rnd_tgt();
      logic [31:0] r;
      r = $urandom;
      if (r[31:30] == 2'd0) return 32'hFFFF_FFF0 | {28'd0, r[3:0]};
      return {20'd0, r[11:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      ntests++;
      if (act !== want) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // One clock of stimulus: memory responder, decode ready, branches.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (rel) begin
         rst_n   = 1'b1;
         rel     = 1'b0;
         rel_cyc = cyc;
      end
      #1;
      if (rst_n && prev_rst && prev_req && !prev_gnt) begin
         chk("hold_req", 32'(req), 32'd1);
         chk("hold_addr", addr, prev_addr);
      end
      rvalid = 1'b0;
      rdata  = '0;
      if (stale) begin
         rvalid = 1'b1;
         rdata  = 32'hDEAD_BEEF;
         stale  = 1'b0;
      end else if (pend.size() != 0 && pend[0].t <= cyc) begin
         rvalid = 1'b1;
         rdata  = memf(pend[0].a);
         void'(pend.pop_front());
      end else if (pend.size() == 0 && int'($urandom_range(99)) < spur_pct) begin
         rvalid = 1'b1;
         rdata  = $urandom;
      end
      gnt = int'($urandom_range(99)) < gnt_pct;
      if (rst_n && req && gnt) begin
         pend.push_back('{a: addr, t: cyc + int'($urandom_range(dly_hi, dly_lo))});
         ngrant++;
      end
      ready  = int'($urandom_range(99)) < rdy_pct;
      branch = 1'b0;
      if (rst_n && (frc_br || int'($urandom_range(99)) < br_pct)) begin
         branch   = 1'b1;
         target   = frc_br ? frc_tgt : rnd_tgt();
         frc_br   = 1'b0;
         exp_q.delete();
         exp_next = {target[31:2], 2'b00};
      end
      while (exp_q.size() < 16) begin
         exp_q.push_back(exp_next);
         exp_next += 32'd4;
      end
      if (rst_n && pend.size() > DEPTH) begin
         chk("outstanding_bound", 32'(pend.size()), 32'(DEPTH));
      end
      prev_req  = req;
      prev_gnt  = gnt;
      prev_addr = addr;
      prev_rst  = rst_n;
   endtask

   task automatic reset_dut(input bit with_stale);
      rst_n    = 1'b0;
      pend.delete();
      exp_q.delete();
      exp_next = BOOT;
      first_v  = -1;
      repeat (2) begin
         step();
         chk("rst_req", 32'(req), 32'd0);
         chk("rst_addr", addr, BOOT);
         chk("rst_valid", 32'(valid), 32'd0);
         chk("rst_instr", instr, 32'd0);
         chk("rst_pc", pc, 32'd0);
         chk("rst_misaligned", 32'(misaligned), 32'd0);
      end
      rel   = 1'b1;
      stale = with_stale;
   endtask

   // Monitor: compares every accepted instruction against the expected stream.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            mis_exp = 1'b0;
         end else begin
            chk("misaligned", 32'(misaligned), 32'(mis_exp));
            if (valid && first_v < 0) first_v = cyc;
            if (valid && ready && !branch) begin
               if (exp_q.size() == 0) begin
                  ntests++;
                  nfail++;
                  $display("FAIL pop_unexpected: got pc %h expected none", pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("pc", pc, e);
                  chk("instr", instr, memf(e));
                  npop++;
               end
            end
            mis_exp = MIS_EN && branch && (target[1:0] != 2'b00);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int g0;
      int p0;
      int k;

      // Basic streaming latency
      reset_dut(1'b0);
      step();
      chk("first_req", 32'(req), 32'd1);
      chk("first_addr", addr, BOOT);
      p0 = npop;
      repeat (6) step();
      chk("first_valid_cycle", 32'(first_v - rel_cyc), 32'd2);
      chk("stream_progress", 32'(npop - p0 >= 3), 32'd1);

      // Decode stalled: credit limits fetches to the FIFO depth
      rdy_pct = 0;
      reset_dut(1'b0);
      g0 = ngrant;
      step();
      repeat (10) step();
      chk("stall_grants", 32'(ngrant - g0), 32'(DEPTH));
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_head_pc", pc, BOOT);
      rdy_pct = 100;
      p0 = npop;
      repeat (8) step();
      chk("resume_progress", 32'(npop - p0 >= 3), 32'd1);

      // Grant withheld: request and address held
      gnt_pct = 0;
      reset_dut(1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("nogrant_req", 32'(req), 32'd1);
         chk("nogrant_addr", addr, BOOT);
      end
      gnt_pct = 100;
      repeat (6) step();

      // Branch with two responses outstanding
      dly_lo = 3;
      dly_hi = 3;
      reset_dut(1'b0);
      step();
      step();
      chk("two_outstanding", 32'(pend.size()), 32'd2);
      frc_br  = 1'b1;
      frc_tgt = 32'h0000_0100;
      step();
      step();
      chk("flush_valid", 32'(valid), 32'd0);
      p0 = npop;
      repeat (14) step();
      chk("after_branch_progress", 32'(npop - p0 >= 1), 32'd1);

      // Misaligned branch while waiting for grant
      dly_lo  = 1;
      dly_hi  = 1;
      gnt_pct = 0;
      reset_dut(1'b0);
      step();
      frc_br  = 1'b1;
      frc_tgt = 32'h0000_0102;
      step();
      step();
      chk("redirect_hold_addr", addr, BOOT);
      chk("redirect_hold_req", 32'(req), 32'd1);
      chk("misaligned_pulse", 32'(misaligned), 32'(MIS_EN));
      step();
      chk("redirect_hold_addr2", addr, BOOT);
      gnt_pct = 100;
      step();
      step();
      chk("redirect_addr", addr, 32'h0000_0100);
      p0 = npop;
      repeat (10) step();
      chk("redirect_progress", 32'(npop - p0 >= 1), 32'd1);

      // Address wrap at the top of memory
      frc_br  = 1'b1;
      frc_tgt = 32'hFFFF_FFFC;
      step();
      step();
      chk("wrap_start", addr, 32'hFFFF_FFFC);
      k = 0;
      while (addr == 32'hFFFF_FFFC && k < 20) begin
         step();
         k++;
      end
      chk("wrap_addr", addr, 32'h0000_0000);
      repeat (10) step();

      // Random traffic with mid-transaction resets and stale responses
      gnt_pct  = 70;
      dly_lo   = 1;
      dly_hi   = 4;
      rdy_pct  = 70;
      br_pct   = 3;
      spur_pct = 10;
      for (int r = 0; r < 4; r++) begin
         repeat (1500) step();
         reset_dut(1'b1);
         step();
      end
      repeat (20) step();
      chk("total_progress", 32'(npop > 500), 32'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
